// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encodings,
// parameter defaults and a word-alignment helper.
package if_fetch_unit_pkg;

  // FSM state encodings (plain constants for legacy-tool compatibility)
  localparam logic [1:0] FETCH_REQ  = 2'd0;
  localparam logic [1:0] FETCH_WAIT = 2'd1;
  localparam logic [1:0] FETCH_HOLD = 2'd2;

  // Parameter defaults
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned PC_STEP_DEFAULT  = 4;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  // Clear the byte-offset bits so every fetch address is word aligned
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_fetch_unit_pc_next.sv
// Combinational next-PC select for the fetch stage.
// Priority: redirect (aligned target) > sequential increment > hold.
module if_pc_next
  import if_fetch_unit_pkg::*;
#(
  parameter int unsigned PC_STEP = PC_STEP_DEFAULT
) (
  input  logic [31:0] pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        advance,
  output logic [31:0] pc_next
);

  // Redirect wins over advance; increment wraps modulo 2^32
  always_comb begin
    pc_next = pc;
    if (redirect_valid) begin
      pc_next = align_word(redirect_pc);
    end else if (advance) begin
      pc_next = pc + 32'(PC_STEP);
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage feeding the IF/ID register.
// Single-outstanding req/gnt/rvalid handshake to instruction memory, with
// redirect handling and discard of stale in-flight responses.
// Optional: define IF_PERF_CNT_EN to add perf_fetch_cnt / perf_stall_cnt.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
`ifdef IF_PERF_CNT_EN
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt,
`endif
  input  logic        pc_write,
  input  logic        dstall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic        istall
);

  logic [1:0]  state;
  logic [1:0]  state_next;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        drop;
  logic        drop_next;
  logic        load_inst;
  logic        advance;

  // Outputs derived from state; reset cycle forces a stalled, idle interface
  always_comb begin
    istall    = ~rst | (state != FETCH_HOLD);
    imem_req  = rst & (state == FETCH_REQ);
    imem_addr = pc;
    advance   = pc_write & ~dstall & ~istall;
  end

  if_pc_next #(
    .PC_STEP(PC_STEP)
  ) u_pc_next (
    .pc            (pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .advance       (advance),
    .pc_next       (pc_next)
  );

  // Next-state logic for the fetch FSM and the stale-response drop flag
  always_comb begin
    state_next = state;
    drop_next  = drop;
    load_inst  = 1'b0;
    case (state)
      FETCH_REQ: begin
        // A redirect alongside the grant means the granted address is stale
        if (imem_gnt) begin
          state_next = FETCH_WAIT;
          drop_next  = redirect_valid;
        end
      end
      FETCH_WAIT: begin
        if (imem_rvalid) begin
          drop_next = 1'b0;
          if (drop || redirect_valid) begin
            state_next = FETCH_REQ;
          end else begin
            state_next = FETCH_HOLD;
            load_inst  = 1'b1;
          end
        end else if (redirect_valid) begin
          drop_next = 1'b1;
        end
      end
      FETCH_HOLD: begin
        if (redirect_valid || advance) begin
          state_next = FETCH_REQ;
        end
      end
      default: begin
        state_next = FETCH_REQ;
        drop_next  = 1'b0;
      end
    endcase
  end

  // State, PC and IF/ID output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= FETCH_REQ;
      pc       <= align_word(RESET_PC);
      drop     <= 1'b0;
      inst_out <= '0;
      pc_out   <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      drop  <= drop_next;
      if (load_inst) begin
        inst_out <= imem_rdata;
        pc_out   <= pc;
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  // Performance counters: consumed instructions and stalled cycles, wrapping
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (advance) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
      if (istall) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios followed by
// randomized stimulus, all compared against a transaction-level model.
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_write;
  logic        dstall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic        istall;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  if_fetch_unit u_dut (
    .clk           (clk),
    .rst           (rst),
`ifdef IF_PERF_CNT_EN
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_stall_cnt(perf_stall_cnt),
`endif
    .pc_write      (pc_write),
    .dstall        (dstall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .inst_out      (inst_out),
    .pc_out        (pc_out),
    .istall        (istall)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Stimulus controls for the next cycle
  logic        d_rst, d_pw, d_ds, d_redir, d_gnt_ok, rand_lat;
  logic [31:0] d_rpc;
  int          fix_lat;

  // Reference model: what has been fetched, what is in flight, what is held
  logic [31:0] m_pc, m_inst, m_pcout, m_fetch, m_stall;
  logic        m_busy, m_drop, m_have;

  // Memory model: one response slot with a countdown
  logic        mem_pend;
  logic [31:0] mem_addr;
  int          mem_cnt;

  // Observations for directed checks
  logic [31:0] grant_addrs[$];
  int          istall_low;
  int          req_seen;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h8) return 32'hDEAD_BEEF;
    if (a[4]) return NOP_INSN;
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic cycle();
    logic        exp_req, exp_istall;
    logic [31:0] tgt;
    @(negedge clk);
    exp_req        = d_rst && !m_busy && !m_have;
    exp_istall     = !d_rst || !m_have;
    rst            = d_rst;
    pc_write       = d_pw;
    dstall         = d_ds;
    redirect_valid = d_redir;
    redirect_pc    = d_rpc;
    imem_gnt       = d_gnt_ok && exp_req;
    imem_rvalid    = mem_pend && (mem_cnt == 0);
    imem_rdata     = imem_rvalid ? mem_word(mem_addr) : $urandom;
    #1;
    check_eq("imem_req", imem_req, exp_req);
    if (exp_req) check_eq("imem_addr", imem_addr, m_pc);
    check_eq("istall", istall, exp_istall);
    check_eq("inst_out", inst_out, m_inst);
    check_eq("pc_out", pc_out, m_pcout);
`ifdef IF_PERF_CNT_EN
    check_eq("perf_fetch_cnt", perf_fetch_cnt, m_fetch);
    check_eq("perf_stall_cnt", perf_stall_cnt, m_stall);
`endif
    if (imem_req && imem_gnt) grant_addrs.push_back(imem_addr);
    if (!istall) istall_low++;
    if (imem_req) req_seen++;
    @(posedge clk);
    // Memory side (uses the pre-edge PC as the granted address)
    if (imem_rvalid) mem_pend = 1'b0;
    else if (mem_pend) mem_cnt--;
    if (imem_gnt) begin
      mem_pend = 1'b1;
      mem_addr = m_pc;
      mem_cnt  = rand_lat ? int'($urandom_range(0, 3)) : fix_lat;
    end
    // Fetch-stage model
    if (!d_rst) begin
      m_pc = RESET_PC_DEFAULT; m_busy = 0; m_drop = 0; m_have = 0;
      m_inst = 0; m_pcout = 0; m_fetch = 0; m_stall = 0;
    end else begin
      tgt = d_rpc & 32'hFFFF_FFFC;
      if (exp_istall) m_stall++;
      if (m_have) begin
        if (d_redir) begin
          m_pc = tgt; m_have = 0;
        end else if (d_pw && !d_ds) begin
          m_pc = m_pc + 32'd4; m_have = 0; m_fetch++;
        end
      end else if (!m_busy) begin
        if (imem_gnt) begin m_busy = 1; m_drop = d_redir; end
        if (d_redir) m_pc = tgt;
      end else begin
        if (imem_rvalid) begin
          m_busy = 0;
          if (!m_drop && !d_redir) begin
            m_have = 1; m_inst = mem_word(mem_addr); m_pcout = m_pc;
          end
          m_drop = 0;
        end else if (d_redir) begin
          m_drop = 1;
        end
        if (d_redir) m_pc = tgt;
      end
    end
  endtask

  task automatic set_idle();
    d_rst = 1; d_pw = 1; d_ds = 0; d_redir = 0; d_rpc = 0;
    d_gnt_ok = 1; rand_lat = 0; fix_lat = 0;
  endtask

  task automatic do_reset();
    set_idle();
    d_rst = 0;
    cycle(); cycle();
    d_rst = 1;
  endtask

  // Park the fetch unit in the held state at addr with downstream frozen
  task automatic reach_hold(input logic [31:0] addr);
    d_gnt_ok = 0; d_redir = 1; d_rpc = addr; cycle();
    d_redir = 0; d_ds = 1; d_gnt_ok = 1; fix_lat = 0;
    cycle(); cycle();
  endtask

  logic [31:0] f0;

  initial begin
    rst = 0; pc_write = 0; dstall = 0; redirect_valid = 0; redirect_pc = 0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
    m_pc = RESET_PC_DEFAULT; m_busy = 0; m_drop = 0; m_have = 0;
    m_inst = 0; m_pcout = 0; m_fetch = 0; m_stall = 0;
    mem_pend = 0; mem_addr = 0; mem_cnt = 0;
    istall_low = 0; req_seen = 0; f0 = 0;
    set_idle();

    // 1: zero-wait streaming from reset
    do_reset();
    grant_addrs.delete(); istall_low = 0;
    cycle(); cycle();
    #1;
    check_eq("t1_first_istall", istall, 1'b0);
    check_eq("t1_first_pc", pc_out, 32'h0);
    check_eq("t1_first_inst", inst_out, 32'h0050_0093);
    repeat (7) cycle();
    check_eq("t1_ngrants", grant_addrs.size(), 3);
    if (grant_addrs.size() >= 3) begin
      check_eq("t1_addr0", grant_addrs[0], 32'h0);
      check_eq("t1_addr1", grant_addrs[1], 32'h4);
      check_eq("t1_addr2", grant_addrs[2], 32'h8);
    end
    check_eq("t1_istall_low", istall_low, 3);

    // 2: downstream stall while holding pc 0x10
    do_reset();
    reach_hold(32'h10);
    #1;
    check_eq("t2_hold_pc", pc_out, 32'h10);
    req_seen = 0; istall_low = 0;
    repeat (5) cycle();
    check_eq("t2_no_req", req_seen, 0);
    check_eq("t2_istall_low", istall_low, 5);
    check_eq("t2_pc_stable", pc_out, 32'h10);
    check_eq("t2_inst_stable", inst_out, NOP_INSN);
    d_ds = 0; cycle();
    #1;
    check_eq("t2_next_req", imem_req, 1'b1);
    check_eq("t2_next_addr", imem_addr, 32'h14);

    // 3: redirect during WAIT, late response is discarded
    do_reset();
    d_gnt_ok = 0; d_redir = 1; d_rpc = 32'h8; cycle();
    d_redir = 0; d_gnt_ok = 1; fix_lat = 2; cycle();
    d_gnt_ok = 0; istall_low = 0;
    d_redir = 1; d_rpc = 32'h200; cycle();
    d_redir = 0; cycle(); cycle();
    #1;
    check_eq("t3_istall_low", istall_low, 0);
    check_eq("t3_istall", istall, 1'b1);
    check_eq("t3_inst", inst_out, 32'h0);
    check_eq("t3_req", imem_req, 1'b1);
    check_eq("t3_addr", imem_addr, 32'h200);

    // 4: redirect and advance together in HOLD, target unaligned
    do_reset();
    reach_hold(32'h40);
    d_ds = 0; d_pw = 1; d_redir = 1; d_rpc = 32'h103; cycle();
    d_redir = 0; d_gnt_ok = 0;
    #1;
    check_eq("t4_addr", imem_addr, 32'h100);
    check_eq("t4_istall", istall, 1'b1);

    // 5: reset during WAIT, stale response afterwards
    do_reset();
    d_gnt_ok = 0; d_redir = 1; d_rpc = 32'h60; cycle();
    d_redir = 0; d_gnt_ok = 1; fix_lat = 3; cycle();
    d_gnt_ok = 0; cycle();
    d_rst = 0; cycle();
    d_rst = 1; cycle(); cycle(); cycle();
    #1;
    check_eq("t5_stale_gone", mem_pend, 1'b0);
    check_eq("t5_req", imem_req, 1'b1);
    check_eq("t5_addr", imem_addr, RESET_PC_DEFAULT);
    check_eq("t5_inst", inst_out, 32'h0);
    check_eq("t5_istall", istall, 1'b1);

    // 6: PC wrap
    do_reset();
    reach_hold(32'hFFFF_FFFC);
    #1;
    check_eq("t6_hold_pc", pc_out, 32'hFFFF_FFFC);
`ifdef IF_PERF_CNT_EN
    f0 = perf_fetch_cnt;
`endif
    d_ds = 0; d_gnt_ok = 0; cycle();
    #1;
    check_eq("t6_wrap_addr", imem_addr, 32'h0);
`ifdef IF_PERF_CNT_EN
    check_eq("t6_perf_delta", perf_fetch_cnt - f0, 32'd1);
`endif

    // Randomized traffic
    do_reset();
    rand_lat = 1;
    for (int i = 0; i < 3000; i++) begin
      d_rst    = ($urandom_range(0, 59) != 0);
      d_pw     = ($urandom_range(0, 3) != 0);
      d_ds     = ($urandom_range(0, 3) == 0);
      d_redir  = ($urandom_range(0, 7) == 0);
      d_rpc    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom;
      d_gnt_ok = ($urandom_range(0, 1) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage, directly upstream of the IF/ID pipeline register.
- Owns the PC and runs a single-outstanding request/grant/response handshake to instruction memory.
- Presents the fetched instruction and its PC to IF/ID and drives istall while no valid instruction is available.
- Accepts branch/jump redirects from later stages and discards stale in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
PC_STEP, 4, sequential PC increment in bytes.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, synchronous, active-low: state clears on a rising clk edge while rst==0.
pc_write  in  1  hazard-unit write enable, same sense as IF/ID write enable; 1 = downstream may accept.
dstall  in  1  data-memory stall; 1 = downstream frozen.
redirect_valid  in  1  taken branch/jump this cycle.
redirect_pc  in  32  redirect target.
imem_req  out  1  fetch request.
imem_addr  out  32  fetch address, word aligned.
imem_gnt  in  1  memory accepted the request this cycle.
imem_rvalid  in  1  response data valid.
imem_rdata  in  32  response instruction.
inst_out  out  32  instruction to IF/ID.
pc_out  out  32  PC of inst_out.
istall  out  1  1 = inst_out/pc_out not valid.

Behaviour:
- advance = pc_write & ~dstall & ~istall. The instruction is consumed by IF/ID on that edge.
- Reset (rst==0 at edge) forces these values:
  - state=REQ, pc=RESET_PC, drop=0.
  - inst_out=0, pc_out=0, istall=1, imem_req=0 during the reset cycle.
  - Reset mid-transaction abandons it. Any later rvalid for the abandoned request is ignored until a new grant occurs.
- States: REQ, WAIT, HOLD.
- REQ:
  - imem_req=1, imem_addr=pc, istall=1.
  - On gnt go to WAIT.
  - A redirect without gnt loads pc and stays in REQ; the address changes while ungranted, which memory tolerates.
  - A redirect with gnt loads pc, goes to WAIT and sets drop=1.
- WAIT:
  - imem_req=0, istall=1.
  - On rvalid with drop=0 and no redirect: latch inst_out=imem_rdata and pc_out=pc, then go to HOLD.
  - On rvalid with drop=1: discard, clear drop, go to REQ.
  - A redirect in WAIT loads pc and sets drop=1. If rvalid arrives in the same cycle, discard and go to REQ.
- HOLD:
  - istall=0; inst_out and pc_out are stable.
  - On advance: pc <= pc+PC_STEP, go to REQ.
  - Otherwise hold.
  - A redirect has priority over advance: drop the held instruction, pc <= redirect_pc, go to REQ, istall=1 from the next cycle.
- redirect_pc[1:0] is forced to 2'b00.
- pc wraps modulo 2^32, so 32'hFFFF_FFFC + 4 = 0.
- When istall=1, inst_out and pc_out keep their last values; IF/ID inserts the bubble.
- Minimum latency: 2 cycles from request issue to istall=0 (gnt in REQ, rvalid in the next WAIT cycle).
- Throughput is 1 instruction per 3 cycles with zero-wait memory. This is accepted for now.

Optional Feature:
IF_PERF_CNT_EN
- Defined:
  - Adds outputs perf_fetch_cnt[31:0], incremented on each advance.
  - Adds outputs perf_stall_cnt[31:0], incremented each cycle istall=1 outside reset.
  - Both counters clear on reset and wrap silently.
- Undefined: the ports and logic are absent, and the other behaviour is identical.

Decomposition:
- Shared package/header holds:
  - state encodings FETCH_REQ=2'd0, FETCH_WAIT=2'd1, FETCH_HOLD=2'd2;
  - the PC_STEP and RESET_PC defaults;
  - the NOP encoding 32'h0000_0013 for bench use.
- One sub-module, if_pc_next: combinational next-PC select across redirect, increment and hold, including the alignment masking.
- FSM and output registers stay in the top.

Test Plan:
1. Reset then zero-wait memory returning 32'h00500093 at addr 0, with pc_write=1 and dstall=0:
   - imem_addr sequence 0,4,8;
   - istall low one cycle in every three;
   - pc_out=0 with inst_out=32'h00500093.
2. In HOLD with pc_out=0x10, hold dstall=1 for 5 cycles:
   - inst_out/pc_out unchanged, istall=0, no new imem_req;
   - after release, the next imem_addr is 0x14.
3. Redirect to 0x200 while in WAIT for addr 0x8, with rvalid 2 cycles later carrying 0xDEADBEEF:
   - data discarded, istall stays 1;
   - next imem_addr=0x200.
4. Redirect to 0x103 asserted in the same cycle as advance in HOLD:
   - imem_addr=0x100, not pc+4.
5. Assert rst low while in WAIT, then return an rvalid for the abandoned request:
   - after reset, imem_addr=RESET_PC;
   - the stale rvalid has no effect on inst_out.
6. Start at pc=0xFFFF_FFFC, then advance:
   - next imem_addr=0x0000_0000.
   - With IF_PERF_CNT_EN defined, perf_fetch_cnt increments by exactly 1.
